// File: rtl/instr_encoder_if.sv
// Field-bundle stream into the encoder and the IMEM write port out of it.
// The master side is the program loader / bench; the slave side is the encoder.
interface instr_encoder_if #(
   parameter int ADDR_W = 10
) ();
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        fmt;
   logic [6:0]        opcode;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [31:0]       imm;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ready;
   logic [ADDR_W:0]   count;
   logic              err;
   logic              busy;

   modport master (
      output start, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata, count, err, busy
   );

   modport slave (
      input  start, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata, count, err, busy
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I instruction fields into machine words and streams them into IMEM
// at auto-incrementing word addresses through a single-entry output register.
module instr_encoder #(
   parameter int                ADDR_W    = 10,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input logic            clk,
   input logic            reset_n,
   instr_encoder_if.slave bus
);
   typedef enum logic [2:0] {
      FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
      FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
   } fmt_e;

   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   logic              pending;
   logic [31:0]       memWdata;
   logic [ADDR_W-1:0] memAddr;
   logic [ADDR_W:0]   count;
   logic              err;
   logic [31:0]       encWord;
   logic              fmtLegal, misaligned, inReady, accept, acceptWord, drain;

   always_comb begin
      encWord = '0;
      case (bus.fmt)
         FMT_R: encWord = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
         FMT_I: encWord = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
         FMT_S: encWord = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
         FMT_B: encWord = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                           bus.imm[4:1], bus.imm[11], bus.opcode};
         FMT_U: encWord = {bus.imm[31:12], bus.rd, bus.opcode};
         FMT_J: encWord = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                           bus.rd, bus.opcode};
         default: encWord = '0;
      endcase
   end

   // in_ready looks straight through to mem_ready so a draining slot can refill same cycle
   assign fmtLegal   = (bus.fmt <= FMT_J);
   assign misaligned = ((bus.fmt == FMT_B) || (bus.fmt == FMT_J)) && bus.imm[0];
   assign inReady    = !bus.start && (!pending || bus.mem_ready);
   assign accept     = bus.in_valid && inReady;
   assign acceptWord = accept && fmtLegal;
   assign drain      = pending && bus.mem_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending  <= 1'b0;
         memWdata <= '0;
         memAddr  <= BASE_ADDR;
         count    <= '0;
         err      <= 1'b0;
      end else if (bus.start) begin
         pending <= 1'b0;
         memAddr <= BASE_ADDR;
         count   <= '0;
         err     <= 1'b0;
      end else begin
         if (drain) begin
            memAddr <= memAddr + ADDR_W'(1);
            if (memAddr == {ADDR_W{1'b1}}) err <= 1'b1;
            if (count != CNT_MAX) count <= count + (ADDR_W+1)'(1);
         end
         if (acceptWord) begin
            memWdata <= encWord;
            pending  <= 1'b1;
         end else if (drain) begin
            pending <= 1'b0;
         end
         if (accept && (!fmtLegal || misaligned)) err <= 1'b1;
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.mem_we    = pending;
   assign bus.busy      = pending;
   assign bus.mem_addr  = memAddr;
   assign bus.mem_wdata = memWdata;
   assign bus.count     = count;
   assign bus.err       = err;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table of known RV32I encodings plus
// stall / illegal / start / wrap / reset sequences, checked through a scoreboard queue.
module tb_instr_encoder;
   localparam int AW = 10;

   typedef struct {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   word;
   } sb_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   sb_t  sbQ[$];
   logic [AW-1:0] nextAddr = '0;
   logic [31:0]   curExp = '0;
   vec_t tab[10];

   instr_encoder_if #(.ADDR_W(AW)) bus ();

   instr_encoder #(.ADDR_W(AW), .BASE_ADDR('0)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Negedge sample point: retire a drained word, then record a newly accepted one.
   task automatic sample();
      sb_t e;
      @(negedge clk);
      if (reset_n && !bus.start && bus.mem_we && bus.mem_ready) begin
         if (sbQ.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_unexpected: write addr 0x%0h data 0x%0h, expected none",
                     bus.mem_addr, bus.mem_wdata);
         end else begin
            e = sbQ.pop_front();
            chk("sb_addr", 64'(bus.mem_addr), 64'(e.addr));
            chk("sb_data", 64'(bus.mem_wdata), 64'(e.word));
         end
      end
      if (reset_n && bus.in_valid && bus.in_ready && bus.fmt <= 3'd5) begin
         e.addr = nextAddr;
         e.word = curExp;
         sbQ.push_back(e);
         nextAddr = nextAddr + AW'(1);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      bus.in_valid = 1'b1;
      bus.fmt      = v.fmt;
      bus.opcode   = v.opcode;
      bus.rd       = v.rd;
      bus.rs1      = v.rs1;
      bus.rs2      = v.rs2;
      bus.funct3   = v.funct3;
      bus.funct7   = v.funct7;
      bus.imm      = v.imm;
      curExp       = v.exp;
   endtask

   task automatic idle2();
      bus.in_valid = 1'b0;
      sample(); cycle();
      sample();
   endtask

   initial begin
      vec_t v;
      //          fmt   opcode     rd     rs1    rs2    f3    f7      imm            expected
      tab[0] = '{3'd1, 7'h03, 5'd5,  5'd2,  5'd9,  3'd2, 7'h55, 32'h0000_0008, 32'h0081_2283}; // lw x5,8(x2)
      tab[1] = '{3'd0, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3}; // add x3,x1,x2
      tab[2] = '{3'd2, 7'h23, 5'd17, 5'd2,  5'd6,  3'd2, 7'h7F, 32'h0000_000C, 32'h0061_2623}; // sw x6,12(x2)
      tab[3] = '{3'd3, 7'h63, 5'd31, 5'd1,  5'd2,  3'd0, 7'h11, 32'hFFFF_FFF8, 32'hFE20_8CE3}; // beq x1,x2,-8
      tab[4] = '{3'd4, 7'h37, 5'd10, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5000, 32'h1234_5537}; // lui x10
      tab[5] = '{3'd1, 7'h13, 5'd1,  5'd0,  5'd4,  3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093}; // addi x1,x0,-1
      tab[6] = '{3'd1, 7'h13, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hABCD_E123, 32'h1230_0013}; // truncated imm
      tab[7] = '{3'd5, 7'h6F, 5'd0,  5'd7,  5'd8,  3'd5, 7'h22, 32'hFFFF_FFFC, 32'hFFDF_F06F}; // jal x0,-4
      tab[8] = '{3'd2, 7'h23, 5'd0,  5'd1,  5'd5,  3'd2, 7'h00, 32'hFFFF_FFFC, 32'hFE50_AE23}; // sw x5,-4(x1)
      tab[9] = '{3'd0, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'h0000_0000, 32'h4020_81B3}; // sub x3,x1,x2

      bus.start = 1'b0; bus.in_valid = 1'b0; bus.mem_ready = 1'b0;
      bus.fmt = '0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
      bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;

      // reset values
      sample();
      chk("rst_memWe", 64'(bus.mem_we), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_memAddr", 64'(bus.mem_addr), 64'd0);
      chk("rst_memWdata", 64'(bus.mem_wdata), 64'd0);
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_err", 64'(bus.err), 64'd0);
      chk("rst_inReady", 64'(bus.in_ready), 64'd1);
      cycle();
      reset_n = 1'b1;
      bus.mem_ready = 1'b1;
      sample(); cycle();

      // back-to-back vectors at full throughput
      for (int i = 0; i < 10; i++) begin
         drive(tab[i]);
         sample();
         chk("b2b_inReady", 64'(bus.in_ready), 64'd1);
         if (i > 0) chk("lat_memWe", 64'(bus.mem_we), 64'd1);
         cycle();
      end
      idle2();
      chk("b2b_count", 64'(bus.count), 64'd10);
      chk("b2b_addr", 64'(bus.mem_addr), 64'd10);
      chk("b2b_busy", 64'(bus.busy), 64'd0);
      chk("b2b_err", 64'(bus.err), 64'd0);
      cycle();

      // IMEM stall: word and address held, in_ready low
      bus.mem_ready = 1'b0;
      v = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0010, 32'h0100_00EF};
      drive(v);
      sample(); cycle();
      bus.in_valid = 1'b0;
      for (int s = 0; s < 3; s++) begin
         sample();
         chk("stall_memWe", 64'(bus.mem_we), 64'd1);
         chk("stall_addr", 64'(bus.mem_addr), 64'd10);
         chk("stall_data", 64'(bus.mem_wdata), 64'h0100_00EF);
         chk("stall_inReady", 64'(bus.in_ready), 64'd0);
         cycle();
      end
      bus.mem_ready = 1'b1;
      sample(); cycle();
      sample();
      chk("stall_addrAdv", 64'(bus.mem_addr), 64'd11);
      chk("stall_count", 64'(bus.count), 64'd11);
      cycle();

      // illegal fmt consumed without a write, then misaligned J
      v = '{3'd6, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h0, 32'h0};
      drive(v);
      sample();
      chk("ill_inReady", 64'(bus.in_ready), 64'd1);
      cycle();
      v = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0011, 32'h0100_00EF};
      drive(v);
      sample();
      chk("ill_err", 64'(bus.err), 64'd1);
      chk("ill_noWrite", 64'(bus.mem_we), 64'd0);
      chk("ill_count", 64'(bus.count), 64'd11);
      cycle();
      idle2();
      chk("ill_jCount", 64'(bus.count), 64'd12);
      chk("ill_jAddr", 64'(bus.mem_addr), 64'd12);
      cycle();

      // start discards a pending word and blocks a same-cycle bundle
      bus.mem_ready = 1'b0;
      drive(tab[1]);
      sample(); cycle();
      bus.start = 1'b1;
      bus.mem_ready = 1'b1;
      drive(tab[2]);
      sample();
      chk("start_inReady", 64'(bus.in_ready), 64'd0);
      cycle();
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      sbQ.delete();
      nextAddr = '0;
      sample();
      chk("start_memWe", 64'(bus.mem_we), 64'd0);
      chk("start_addr", 64'(bus.mem_addr), 64'd0);
      chk("start_count", 64'(bus.count), 64'd0);
      chk("start_err", 64'(bus.err), 64'd0);
      cycle();
      drive(tab[0]);
      sample(); cycle();
      idle2();
      chk("post_count", 64'(bus.count), 64'd1);
      chk("post_err", 64'(bus.err), 64'd0);
      cycle();

      // fill the remaining address space: wrap sets err, count saturates
      for (int k = 0; k < (1 << AW) - 1; k++) begin
         v = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'(k),
               {12'(k), 5'd0, 3'd0, 5'd1, 7'h13}};
         drive(v);
         sample(); cycle();
      end
      idle2();
      chk("wrap_addr", 64'(bus.mem_addr), 64'd0);
      chk("wrap_err", 64'(bus.err), 64'd1);
      chk("wrap_count", 64'(bus.count), 64'(1 << AW));
      cycle();
      drive(tab[5]);
      sample(); cycle();
      idle2();
      chk("sat_count", 64'(bus.count), 64'(1 << AW));
      chk("sat_addr", 64'(bus.mem_addr), 64'd1);
      cycle();

      // start clears err; misaligned B still written with bit 0 dropped
      bus.start = 1'b1;
      sample(); cycle();
      bus.start = 1'b0;
      sbQ.delete();
      nextAddr = '0;
      sample();
      chk("start2_err", 64'(bus.err), 64'd0);
      cycle();
      v = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFF9, 32'hFE20_8CE3};
      drive(v);
      sample(); cycle();
      idle2();
      chk("misB_err", 64'(bus.err), 64'd1);
      chk("misB_count", 64'(bus.count), 64'd1);
      cycle();

      // reset mid-write drops the pending word immediately
      bus.mem_ready = 1'b0;
      drive(tab[3]);
      sample(); cycle();
      bus.in_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("midRst_memWe", 64'(bus.mem_we), 64'd0);
      chk("midRst_addr", 64'(bus.mem_addr), 64'd0);
      chk("midRst_err", 64'(bus.err), 64'd0);
      sbQ.delete();
      nextAddr = '0;
      cycle();
      reset_n = 1'b1;
      bus.mem_ready = 1'b1;
      sample(); cycle();

      chk("sb_empty", 64'(sbQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
